// File: rtl/accum_pkg.sv
// Shared opcode/state types and decode helpers for the accumulator core.
// ACCUM_MULDIV_EN: when defined, MUL (12) and DIV (13) decode as ALU ops.
package accum_pkg;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_LDA   = 8'h01,
    OP_STA   = 8'h02,
    OP_LDPC  = 8'h03,
    OP_JMPA  = 8'h04,
    OP_MOVAB = 8'h05,
    OP_MOVBA = 8'h06,
    OP_JZ    = 8'h07,
    OP_LDI   = 8'h08,
    OP_ADD   = 8'h10,
    OP_SUB   = 8'h11,
    OP_MUL   = 8'h12,
    OP_DIV   = 8'h13,
    OP_AND   = 8'h14,
    OP_OR    = 8'h15,
    OP_XOR   = 8'h16,
    OP_NOT   = 8'h17,
    OP_HALT  = 8'hFF
  } opc_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_OPER,
    S_MEM,
    S_EXEC,
    S_HALTED
  } state_e;

  function automatic logic is_two_word(input logic [7:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_JZ) || (op == OP_LDI);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_LDA) || (op == OP_STA);
  endfunction

  function automatic logic is_alu_op(input logic [7:0] op);
`ifdef ACCUM_MULDIV_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOT);
`else
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOT);
`endif
  endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU for accum_core: result, carry/borrow and zero for ALU opcodes.
// ACCUM_MULDIV_EN: when defined, the multiplier and divider are built.
module accum_alu
  import accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [7:0]        opc_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = a_i;
    carry_o  = 1'b0;
    case (opc_i)
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
`ifdef ACCUM_MULDIV_EN
      OP_MUL: result_o = DATA_W'(a_i * b_i);
      OP_DIV: begin
        if (b_i == '0) begin
          result_o = '1;
          carry_o  = 1'b1;
        end else begin
          result_o = a_i / b_i;
        end
      end
`endif
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      default: result_o = a_i;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/accum_core.sv
// Accumulator CPU core with req/ack memory handshake, zero/carry flags and HALT.
// ACCUM_MULDIV_EN: when defined, opcodes 12/13 perform MUL/DIV; otherwise they are NOPs.
module accum_core
  import accum_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [7:0]        inst_q, inst_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  accum_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .opc_i    (inst_q),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= ADDR_W'(RESET_PC);
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      inst_q   <= '0;
      opnd_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      c_q      <= c_d;
      inst_q   <= inst_d;
      opnd_q   <= opnd_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
    end
  end

  // Every access state spends one cycle with req low (issue) before raising req,
  // which yields the mandatory idle cycle after each ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    c_d      = c_q;
    inst_d   = inst_q;
    opnd_d   = opnd_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          inst_d  = mem_rdata[7:0];
          state_d = is_two_word(mem_rdata[7:0]) ? S_OPER : S_EXEC;
        end
      end

      S_OPER: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q + ADDR_W'(1);
        end else if (mem_ack) begin
          req_d   = 1'b0;
          opnd_d  = mem_rdata;
          state_d = is_mem_op(inst_q) ? S_MEM : S_EXEC;
        end
      end

      S_MEM: begin
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = (inst_q == OP_STA);
          addr_d  = ADDR_W'(opnd_q);
          wdata_d = a_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          // LDA data replaces the operand; EXEC then treats LDA like LDI.
          if (inst_q == OP_LDA) opnd_d = mem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        pc_d    = pc_q + (is_two_word(inst_q) ? ADDR_W'(2) : ADDR_W'(1));
        state_d = S_FETCH;
        if (is_alu_op(inst_q)) begin
          a_d = alu_result;
          z_d = alu_zero;
          c_d = alu_carry;
        end else begin
          case (inst_q)
            OP_LDA, OP_LDI: begin
              a_d = opnd_q;
              z_d = (opnd_q == '0);
              c_d = 1'b0;
            end
            OP_LDPC:  a_d = DATA_W'(pc_q);
            OP_JMPA:  pc_d = ADDR_W'(a_q);
            OP_MOVAB: a_d = b_q;
            OP_MOVBA: b_d = a_q;
            OP_JZ:    if (z_q) pc_d = ADDR_W'(opnd_q);
            OP_HALT: begin
              state_d  = S_HALTED;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_HALTED: begin
        req_d = 1'b0;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_accum_core.sv
// Directed bench for accum_core: memory model with wait states, write scoreboard
// checked by a negedge monitor, plus handshake-stability and final-state checks.
module tb_accum_core;
  import accum_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req, mem_we, mem_ack, halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  mem [256];
  logic [7:0]  img [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  rd_log [$];
  int unsigned wait_n = 0;
  int unsigned wcnt = 0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr, ld_data;

  always #5 clk = ~clk;

  accum_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted)
  );

  assign mem_ack   = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] = ld_data;
    else if (!rst && mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    if (!rst && mem_req && mem_ack && !mem_we) rd_log.push_back(mem_addr);
    if (rst || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: handshake stability while waiting, and scoreboard of completed writes.
  logic        pend = 1'b0;
  logic [16:0] held;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && mem_req) check("hs_stable", {mem_we, mem_addr, mem_wdata}, held);
      if (mem_req && mem_ack && mem_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        else check("wr_data", {mem_addr, mem_wdata}, exp_wr.pop_front());
      end
      pend = mem_req && !mem_ack;
      held = {mem_we, mem_addr, mem_wdata};
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic clear_mem();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
  endtask

  task automatic load(input logic [7:0] base);
    for (int i = 0; i < img.size(); i++) poke(base + 8'(i), img[i]);
  endtask

  task automatic run(output int unsigned cyc);
    int unsigned quiet;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {mem_req, mem_we, halted, mem_addr, mem_wdata}, 32'h0);
    check("reset_regs", {dut.pc_q, dut.a_q, dut.b_q, dut.z_q, dut.c_q}, 32'h0);
    @(negedge clk) rst = 1'b0;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("halt_reached", halted, 1);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req || !halted) quiet++;
    end
    check("quiet_after_halt", quiet, 0);
    check("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic load_t1();
    clear_mem();
    img = {8'h08, 8'h05, 8'h06, 8'h08, 8'h03, 8'h10, 8'h02, 8'h80, 8'hFF};
    load(8'h00);
    poke(8'h80, 8'hEE);
  endtask

  int unsigned cyc;
  int unsigned n;
  logic        found;

  initial begin
    rst = 1'b1;

    // 1: LDI 05; B<=A; LDI 03; ADD; STA 80; HALT, zero wait
    wait_n = 0;
    load_t1();
    exp_wr.push_back({8'h80, 8'h08});
    run(cyc);
    check("t1_cycles", cyc, 26);
    check("t1_m80", mem[8'h80], 8'h08);
    check("t1_zc", {dut.z_q, dut.c_q}, 2'b00);

    // 2: FF+01 wraps, Z=1 C=1, JZ 20 taken; STA 90 at 20 records A
    clear_mem();
    img = {8'h08, 8'hFF, 8'h06, 8'h08, 8'h01, 8'h10, 8'h07, 8'h20};
    load(8'h00);
    img = {8'h02, 8'h90, 8'hFF};
    load(8'h20);
    poke(8'h90, 8'hEE);
    exp_wr.push_back({8'h90, 8'h00});
    run(cyc);
    check("t2_cycles", cyc, 31);
    check("t2_zc", {dut.z_q, dut.c_q}, 2'b11);
    check("t2_m90", mem[8'h90], 8'h00);

    // 3: same as 1 with three wait states per access
    wait_n = 3;
    load_t1();
    exp_wr.push_back({8'h80, 8'h08});
    run(cyc);
    check("t3_cycles", cyc, 56);
    check("t3_m80", mem[8'h80], 8'h08);
    check("t3_zc", {dut.z_q, dut.c_q}, 2'b00);

    // 4: reset while the STA write is outstanding
    load_t1();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dut.state_q == S_MEM && mem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_reach_mem", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_req_dropped", mem_req, 0);
    check("t4_regs", {dut.pc_q, dut.a_q, halted}, 17'h0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_write", mem[8'h80], 8'hEE);
    wait_n = 0;

    // 5: DIV by zero, then MUL after SUB borrow set C
    clear_mem();
    img = {8'h08, 8'h07, 8'h13, 8'h02, 8'h90, 8'h08, 8'h01, 8'h06,
           8'h08, 8'h00, 8'h11, 8'h12, 8'h02, 8'h91, 8'hFF};
    load(8'h00);
`ifdef ACCUM_MULDIV_EN
    exp_wr.push_back({8'h90, 8'hFF});
`else
    exp_wr.push_back({8'h90, 8'h07});
`endif
    exp_wr.push_back({8'h91, 8'hFF});
    run(cyc);
`ifdef ACCUM_MULDIV_EN
    check("t5_zc", {dut.z_q, dut.c_q}, 2'b00);
`else
    check("t5_zc", {dut.z_q, dut.c_q}, 2'b01);
`endif

    // 5b: 10 * 11 keeps the low byte
    clear_mem();
    img = {8'h08, 8'h11, 8'h06, 8'h08, 8'h10, 8'h12, 8'h02, 8'h92, 8'hFF};
    load(8'h00);
    exp_wr.push_back({8'h92, 8'h10});
    run(cyc);
    check("t5b_zc", {dut.z_q, dut.c_q}, 2'b00);

    // 6: jump to FF (NOP), pc wraps to 00 (4A as NOP), then HALT at 01
    clear_mem();
    img = {8'h08, 8'h10, 8'h04};
    load(8'h00);
    img = {8'h08, 8'h4A, 8'h02, 8'h00, 8'h08, 8'hFF, 8'h02, 8'h01, 8'h04};
    load(8'h10);
    exp_wr.push_back({8'h00, 8'h4A});
    exp_wr.push_back({8'h01, 8'hFF});
    run(cyc);
    n = rd_log.size();
    if (n >= 3) check("t6_wrap_fetch", {rd_log[n-3], rd_log[n-2], rd_log[n-1]}, 24'hFF0001);
    else check("t6_wrap_fetch", n, 3);
    check("t6_pc_a", {dut.pc_q, dut.a_q}, 16'h02FF);

    // 7: logic ops, A<=B and A<=pc
    clear_mem();
    img = {8'h08, 8'h0F, 8'h06, 8'h08, 8'h3C, 8'h14, 8'h02, 8'hA0,
           8'h15, 8'h02, 8'hA1, 8'h16, 8'h02, 8'hA2, 8'h17, 8'h02,
           8'hA3, 8'h05, 8'h02, 8'hA4, 8'h03, 8'h02, 8'hA5, 8'hFF};
    load(8'h00);
    exp_wr.push_back({8'hA0, 8'h0C});
    exp_wr.push_back({8'hA1, 8'h0F});
    exp_wr.push_back({8'hA2, 8'h00});
    exp_wr.push_back({8'hA3, 8'hFF});
    exp_wr.push_back({8'hA4, 8'h0F});
    exp_wr.push_back({8'hA5, 8'h14});
    run(cyc);
    check("t7_zc", {dut.z_q, dut.c_q}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
